// File: rtl/guess_ctrl_mp.sv
// Multi-player number-guessing game controller: players take turns guessing,
// each with a bounded number of attempts, until someone hits the secret or all run out.
module guess_ctrl_mp #(
  parameter int NUM_PLAYERS  = 2,
  parameter int MAX_ATTEMPTS = 7,
  parameter int CNT_W        = 8,
  localparam int PW          = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_enter,
  input  logic             i_over,
  input  logic             i_under,
  input  logic             i_equal,
  output logic             o_inc_actual,
  output logic             o_update_leds,
  output logic [PW-1:0]    o_player,
  output logic [CNT_W-1:0] o_attempt,
  output logic             o_win,
  output logic             o_dead,
  output logic [PW-1:0]    o_winner,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    IDLE, GEN_REL, CMP, SHOW, WAIT_PRESS, WAIT_REL, WIN, DEAD
  } state_t;

  // Restart from WIN/DEAD needs a fresh press: see low, then high, then low again.
  typedef enum logic [1:0] {RS_LOW, RS_PRESS, RS_REL} restart_t;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_ATTEMPTS);

  state_t           state, state_nx;
  restart_t         rs, rs_nx;
  logic [PW-1:0]    player;
  logic [PW-1:0]    winner;
  logic [CNT_W-1:0] cnt [NUM_PLAYERS];
  logic             all_done;
  logic             found;
  logic [PW-1:0]    next_player;

  always_comb begin
    all_done = 1'b1;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (cnt[i] < MAX_C) all_done = 1'b0;
    end
  end

  // Round-robin pick: first eligible index above the current one, then wrap
  // around to the lowest eligible index (which may be the current player).
  always_comb begin
    found       = 1'b0;
    next_player = player;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (!found && (PW'(i) > player) && (cnt[i] < MAX_C)) begin
        found       = 1'b1;
        next_player = PW'(i);
      end
    end
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (!found && (PW'(i) <= player) && (cnt[i] < MAX_C)) begin
        found       = 1'b1;
        next_player = PW'(i);
      end
    end
  end

  always_comb begin
    o_attempt = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (PW'(i) == player) o_attempt = cnt[i];
    end
  end

  always_comb begin
    state_nx = state;
    rs_nx    = rs;
    case (state)
      IDLE:       if (i_enter) state_nx = GEN_REL;
      GEN_REL:    if (!i_enter) state_nx = CMP;
      CMP: begin
        if (i_equal) begin
          state_nx = WIN;
          rs_nx    = RS_LOW;
        end else if (i_under || i_over) begin
          state_nx = SHOW;
        end else begin
          state_nx = IDLE;
        end
      end
      SHOW: begin
        if (all_done) begin
          state_nx = DEAD;
          rs_nx    = RS_LOW;
        end else begin
          state_nx = WAIT_PRESS;
        end
      end
      WAIT_PRESS: if (i_enter) state_nx = WAIT_REL;
      WAIT_REL:   if (!i_enter) state_nx = CMP;
      WIN, DEAD: begin
        case (rs)
          RS_LOW:   if (!i_enter) rs_nx = RS_PRESS;
          RS_PRESS: if (i_enter) rs_nx = RS_REL;
          RS_REL:   if (!i_enter) state_nx = IDLE;
          default:  rs_nx = RS_LOW;
        endcase
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      rs     <= RS_LOW;
      player <= '0;
      winner <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) cnt[i] <= '0;
    end else begin
      state <= state_nx;
      rs    <= rs_nx;
      case (state)
        IDLE: begin
          player <= '0;
          for (int i = 0; i < NUM_PLAYERS; i++) cnt[i] <= '0;
        end
        CMP: begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if ((PW'(i) == player) && (cnt[i] < MAX_C)) cnt[i] <= cnt[i] + CNT_W'(1);
          end
          if (i_equal) winner <= player;
        end
        SHOW: if (!all_done) player <= next_player;
        default: ;
      endcase
    end
  end

  assign o_inc_actual  = (state == IDLE);
  assign o_update_leds = (state == SHOW) || (state == WIN);
  assign o_win         = (state == WIN);
  assign o_dead        = (state == DEAD);
  assign o_player      = player;
  assign o_winner      = winner;
  assign dbg_state     = state;

endmodule

// File: tb/tb_guess_ctrl_mp.sv
// Bench for guess_ctrl_mp: three configurations share one stimulus stream and are
// checked every cycle against a game-rules model, plus hand-computed spot values.
module tb_guess_ctrl_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic enter = 1'b0, over = 1'b0, under = 1'b0, equal = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Instance a: defaults. b: 3 players, 2 attempts. c: 1 player, 3 attempts.
  logic       inc_a, leds_a, win_a, dead_a;
  logic [0:0] ply_a, wnr_a;
  logic [7:0] att_a;
  logic [2:0] dbg_a;
  logic       inc_b, leds_b, win_b, dead_b;
  logic [1:0] ply_b, wnr_b;
  logic [7:0] att_b;
  logic [2:0] dbg_b;
  logic       inc_c, leds_c, win_c, dead_c;
  logic [0:0] ply_c, wnr_c;
  logic [7:0] att_c;
  logic [2:0] dbg_c;

  guess_ctrl_mp u_a (
    .clk(clk), .reset_n(rst_n), .i_enter(enter), .i_over(over), .i_under(under),
    .i_equal(equal), .o_inc_actual(inc_a), .o_update_leds(leds_a), .o_player(ply_a),
    .o_attempt(att_a), .o_win(win_a), .o_dead(dead_a), .o_winner(wnr_a), .dbg_state(dbg_a)
  );

  guess_ctrl_mp #(.NUM_PLAYERS(3), .MAX_ATTEMPTS(2)) u_b (
    .clk(clk), .reset_n(rst_n), .i_enter(enter), .i_over(over), .i_under(under),
    .i_equal(equal), .o_inc_actual(inc_b), .o_update_leds(leds_b), .o_player(ply_b),
    .o_attempt(att_b), .o_win(win_b), .o_dead(dead_b), .o_winner(wnr_b), .dbg_state(dbg_b)
  );

  guess_ctrl_mp #(.NUM_PLAYERS(1), .MAX_ATTEMPTS(3)) u_c (
    .clk(clk), .reset_n(rst_n), .i_enter(enter), .i_over(over), .i_under(under),
    .i_equal(equal), .o_inc_actual(inc_c), .o_update_leds(leds_c), .o_player(ply_c),
    .o_attempt(att_c), .o_win(win_c), .o_dead(dead_c), .o_winner(wnr_c), .dbg_state(dbg_c)
  );

  always #5 clk = ~clk;

  // ---------------- game-rules model ----------------
  localparam int P_READY = 0, P_START = 1, P_JUDGE = 2, P_SHOW = 3;
  localparam int P_WAIT = 4, P_HOLD = 5, P_WON = 6, P_DEAD = 7;

  int ph [3];
  int cnt_m [3][8];
  int ply [3];
  int win_p [3];
  bit armed [3];
  bit held [3];

  function automatic int np_of(input int k);
    case (k)
      0: return 2;
      1: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int ma_of(input int k);
    case (k)
      0: return 7;
      1: return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      ph[k] = P_READY; ply[k] = 0; win_p[k] = 0; armed[k] = 0; held[k] = 0;
      for (int p = 0; p < 8; p++) cnt_m[k][p] = 0;
    end
  endtask

  task automatic model_step(input int k);
    int  base;
    int  c;
    bit  all_out;
    bit  picked;
    case (ph[k])
      P_READY: begin
        for (int p = 0; p < 8; p++) cnt_m[k][p] = 0;
        ply[k] = 0;
        if (enter) ph[k] = P_START;
      end
      P_START: if (!enter) ph[k] = P_JUDGE;
      P_JUDGE: begin
        if (cnt_m[k][ply[k]] < ma_of(k)) cnt_m[k][ply[k]] = cnt_m[k][ply[k]] + 1;
        if (equal) begin
          ph[k] = P_WON; win_p[k] = ply[k]; armed[k] = 0; held[k] = 0;
        end else if (under || over) begin
          ph[k] = P_SHOW;
        end else begin
          ph[k] = P_READY;
        end
      end
      P_SHOW: begin
        all_out = 1;
        for (int p = 0; p < np_of(k); p++) if (cnt_m[k][p] < ma_of(k)) all_out = 0;
        if (all_out) begin
          ph[k] = P_DEAD; armed[k] = 0; held[k] = 0;
        end else begin
          base = ply[k];
          picked = 0;
          for (int d = 1; d <= np_of(k); d++) begin
            c = (base + d) % np_of(k);
            if (!picked && cnt_m[k][c] < ma_of(k)) begin
              ply[k] = c; picked = 1;
            end
          end
          ph[k] = P_WAIT;
        end
      end
      P_WAIT: if (enter) ph[k] = P_HOLD;
      P_HOLD: if (!enter) ph[k] = P_JUDGE;
      default: begin
        if (!armed[k]) begin
          if (!enter) armed[k] = 1;
        end else if (!held[k]) begin
          if (enter) held[k] = 1;
        end else if (!enter) begin
          ph[k] = P_READY;
        end
      end
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else for (int k = 0; k < 3; k++) model_step(k);
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int k, input logic inc, input logic leds, input logic w,
                          input logic d, input int p, input int a, input int wn);
    chk($sformatf("m%0d.inc_actual", k), int'(inc), int'(ph[k] == P_READY));
    chk($sformatf("m%0d.update_leds", k), int'(leds), int'(ph[k] == P_SHOW || ph[k] == P_WON));
    chk($sformatf("m%0d.win", k), int'(w), int'(ph[k] == P_WON));
    chk($sformatf("m%0d.dead", k), int'(d), int'(ph[k] == P_DEAD));
    chk($sformatf("m%0d.player", k), p, ply[k]);
    chk($sformatf("m%0d.attempt", k), a, cnt_m[k][ply[k]]);
    chk($sformatf("m%0d.winner", k), wn, win_p[k]);
  endtask

  always @(negedge clk) begin
    cmp_inst(0, inc_a, leds_a, win_a, dead_a, int'(ply_a), int'(att_a), int'(wnr_a));
    cmp_inst(1, inc_b, leds_b, win_b, dead_b, int'(ply_b), int'(att_b), int'(wnr_b));
    cmp_inst(2, inc_c, leds_c, win_c, dead_c, int'(ply_c), int'(att_c), int'(wnr_c));
  end

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enter = 1'b0; over = 1'b0; under = 1'b0; equal = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic guess(input bit ov, input bit un, input bit eq, input int hold);
    over = ov; under = un; equal = eq;
    enter = 1'b1;
    tick(hold);
    enter = 1'b0;
    tick(4);
    over = 1'b0; under = 1'b0; equal = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    do_reset();
    chk("rst.inc", int'(inc_a), 1);
    chk("rst.leds", int'(leds_a), 0);
    chk("rst.win_dead", int'({win_a, dead_a}), 0);
    chk("rst.player", int'(ply_a), 0);
    chk("rst.attempt", int'(att_a), 0);

    // First guess under: one SHOW cycle, attempt visible after CMP, turn passes to 1.
    under = 1'b1; enter = 1'b1;
    tick(2);
    enter = 1'b0;
    tick(1);
    chk("s1.cmp_attempt", int'(att_a), 0);
    tick(1);
    chk("s1.show_leds", int'(leds_a), 1);
    chk("s1.show_attempt_p0", int'(att_a), 1);
    tick(1);
    under = 1'b0;
    chk("s1.leds_drop", int'(leds_a), 0);
    chk("s1.player", int'(ply_a), 1);
    chk("s1.attempt_p1", int'(att_a), 0);

    // Fourteen over guesses exhaust both default players.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      chk("s2.turn", int'(ply_a), i % 2);
      guess(1'b1, 1'b0, 1'b0, 2);
    end
    chk("s2.dead", int'(dead_a), 1);
    chk("s2.player", int'(ply_a), 1);
    chk("s2.attempt", int'(att_a), 7);
    enter = 1'b1; tick(2); enter = 1'b0; tick(2);
    chk("s2.restart_inc", int'(inc_a), 1);
    chk("s2.restart_attempt", int'(att_a), 0);

    // Player 1 wins with equal+under; button already high on WIN entry.
    do_reset();
    guess(1'b1, 1'b0, 1'b0, 2);
    equal = 1'b1; under = 1'b1; enter = 1'b1;
    tick(2);
    enter = 1'b0;
    tick(1);
    enter = 1'b1;
    tick(1);
    equal = 1'b0; under = 1'b0;
    tick(2);
    chk("s3.win", int'(win_a), 1);
    chk("s3.winner", int'(wnr_a), 1);
    chk("s3.leds_held", int'(leds_a), 1);
    enter = 1'b0;
    tick(2);
    chk("s3.stale_press_ignored", int'(win_a), 1);
    enter = 1'b1; tick(1); enter = 1'b0; tick(2);
    chk("s3.restart_inc", int'(inc_a), 1);
    chk("s3.restart_win", int'(win_a), 0);
    chk("s3.restart_attempt", int'(att_a), 0);

    // Long hold counts once.
    do_reset();
    guess(1'b1, 1'b0, 1'b0, 2);
    chk("s4.p1_turn", int'(ply_a), 1);
    guess(1'b1, 1'b0, 1'b0, 50);
    chk("s4.p0_turn", int'(ply_a), 0);
    chk("s4.p0_attempt", int'(att_a), 1);
    guess(1'b1, 1'b0, 1'b0, 1);
    chk("s4.p1_attempt", int'(att_a), 1);

    // No comparison flag returns to IDLE and clears counters.
    guess(1'b0, 1'b0, 1'b0, 2);
    chk("s5.inc", int'(inc_a), 1);
    chk("s5.player", int'(ply_a), 0);
    chk("s5.attempt", int'(att_a), 0);

    // Asynchronous reset while the guess button is held.
    guess(1'b1, 1'b0, 1'b0, 2);
    over = 1'b1; enter = 1'b1;
    tick(3);
    #3 rst_n = 1'b0; enter = 1'b0; over = 1'b0;
    #1;
    chk("s6.async_inc", int'(inc_a), 1);
    chk("s6.async_player", int'(ply_a), 0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    chk("s6.inc", int'(inc_a), 1);
    chk("s6.attempt", int'(att_a), 0);
    chk("s6.leds", int'(leds_a), 0);

    // Three players, two attempts: turns skip exhausted players.
    do_reset();
    for (int i = 0; i < 4; i++) guess(1'b1, 1'b0, 1'b0, 2);
    chk("s7.b_after4_player", int'(ply_b), 1);
    guess(1'b1, 1'b0, 1'b0, 2);
    chk("s7.b_player", int'(ply_b), 2);
    chk("s7.b_attempt", int'(att_b), 1);
    chk("s7.c_player", int'(ply_c), 0);
    chk("s7.c_attempt", int'(att_c), 1);
    guess(1'b1, 1'b0, 1'b0, 2);
    chk("s7.b_dead", int'(dead_b), 1);
    chk("s7.b_final_attempt", int'(att_b), 2);
    chk("s7.c_attempt2", int'(att_c), 2);
    chk("s7.c_dead", int'(dead_c), 0);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
